// File: rtl/uart_rx.sv
// 8-bit UART receiver: 2-flop synchronizer, mid-bit sampling, registered one-clk result pulses.
// Optional even-parity bit is compiled in with macro UART_RX_PARITY_EN.
module uart_rx #(
  parameter int unsigned CLK_FREQ = 100000000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       parity_err
);

  localparam int unsigned BIT_CYC = CLK_FREQ / BAUD;
  localparam logic [15:0] MID_CNT = 16'(BIT_CYC / 2 - 1);
  localparam logic [15:0] END_CNT = 16'(BIT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [7:0]  data_d;
  logic        valid_d, ferr_d;
  logic        rx_meta, rx_s, rx_prev;

  // Synchronizer plus one delayed copy for falling-edge detection in IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic pflag_q, pflag_d;
  logic perr_q, perr_d;
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 16'd0;
      bit_q     <= 3'd0;
      shreg_q   <= 8'h00;
      data      <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pflag_q   <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      data      <= data_d;
      valid     <= valid_d;
      frame_err <= ferr_d;
`ifdef UART_RX_PARITY_EN
      pflag_q   <= pflag_d;
      perr_q    <= perr_d;
`endif
    end
  end

  // Next state and next values of all registered outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    data_d  = data;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    pflag_d = pflag_q;
    perr_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = 16'd0;
        // Requiring rx_prev high keeps a line stuck low after a frame error from restarting
        if (rx_prev && !rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == MID_CNT) begin
          cnt_d = 16'd0;
          bit_d = 3'd0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == END_CNT) begin
          cnt_d   = 16'd0;
          shreg_d = {rx_s, shreg_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == END_CNT) begin
          cnt_d = 16'd0;
          if (rx_s != ^shreg_q) pflag_d = 1'b1;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        // Leave at the stop-bit centre so a back-to-back start bit is not missed
        if (cnt_q == END_CNT) begin
          cnt_d   = 16'd0;
          state_d = IDLE;
          if (!rx_s) begin
            ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            pflag_d = 1'b0;
          end else if (pflag_q) begin
            perr_d  = 1'b1;
            pflag_d = 1'b0;
`endif
          end else begin
            data_d  = shreg_q;
            valid_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected pulses, a negedge monitor pops and checks.
module tb_uart_rx;

  localparam int unsigned CLK_FREQ = 3200000;
  localparam int unsigned BAUD     = 100000;
  localparam int unsigned BIT      = CLK_FREQ / BAUD;

  localparam logic [2:0] K_VALID = 3'b001;
  localparam logic [2:0] K_FERR  = 3'b010;
  localparam logic [2:0] K_PERR  = 3'b100;

  typedef struct {
    logic [2:0] kind;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data;
  logic       valid, frame_err, parity_err;

  exp_t       q[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         pushed = 0;
  int         popped = 0;
  logic [7:0] last_data = 8'h00;

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk(clk), .rst(rst), .rx(rx), .data(data),
    .valid(valid), .frame_err(frame_err), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_pulse(input logic [2:0] kind, input logic [7:0] d);
    exp_t e;
    e.kind = kind;
    e.data = d;
    q.push_back(e);
    pushed++;
  endtask

  task automatic bit_out(input logic b);
    rx = b;
    repeat (BIT) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
`ifdef UART_RX_PARITY_EN
    bit_out(par);
`else
    if (par) begin end
`endif
    bit_out(stop);
  endtask

  // Monitor: every output pulse must match the head of the scoreboard
  always @(negedge clk) begin
    exp_t e;
    logic [2:0] kind;
    if (rst) begin
      last_data = 8'h00;
    end else begin
      kind = {parity_err, frame_err, valid};
      if (kind != 3'b000) begin
        if (q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_pulse: got kind %b data 0x%0h with empty scoreboard at %0t",
                   kind, data, $time);
        end else begin
          e = q.pop_front();
          popped++;
          check("pulse_kind", 32'(kind), 32'(e.kind));
          check("pulse_data", 32'(data), 32'(e.data));
        end
      end
      if (!valid && data !== last_data) begin
        miscompares++;
        $display("FAIL data_hold: got 0x%0h expected 0x%0h at %0t", data, last_data, $time);
      end
      if (valid) last_data = data;
    end
  end

  // Pulses are one clk wide
  logic [2:0] prev_kind = 3'b000;
  always @(negedge clk) begin
    if (!rst && prev_kind != 3'b000 && {parity_err, frame_err, valid} != 3'b000) begin
      miscompares++;
      $display("FAIL pulse_width: got consecutive pulses %b then %b at %0t",
               prev_kind, {parity_err, frame_err, valid}, $time);
    end
    prev_kind = rst ? 3'b000 : {parity_err, frame_err, valid};
  end

  logic [7:0] burst[15] = '{8'h68, 8'h69, 8'h74, 8'h73, 8'h7A, 8'h32, 8'h30, 8'h32,
                            8'h34, 8'h33, 8'h31, 8'h31, 8'h32, 8'h35, 8'h39};
  // Even parity bits of the burst bytes, worked out by hand
  logic       burst_par[15] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1,
                                1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    // Reset values
    #2;
    check("rst_data", 32'(data), 32'h00);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    check("rst_parity_err", 32'(parity_err), 32'h0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3 * BIT) @(posedge clk);
    #1;

    // Single byte
    expect_pulse(K_VALID, 8'h68);
    send_frame(8'h68, 1'b1, 1'b1);
    bit_out(1'b1);

    // Zero-gap burst
    for (int i = 0; i < 15; i++) expect_pulse(K_VALID, burst[i]);
    for (int i = 0; i < 15; i++) send_frame(burst[i], burst_par[i], 1'b1);
    bit_out(1'b1);

    // Short low glitch is a false start, then a real frame
    rx = 1'b0;
    repeat (10) @(posedge clk);
    #1 rx = 1'b1;
    repeat (3 * BIT) @(posedge clk);
    #1;
    expect_pulse(K_VALID, 8'hA5);
    send_frame(8'hA5, 1'b0, 1'b1);
    bit_out(1'b1);

    // Frame error holds previous data; line kept low afterwards must not restart
    expect_pulse(K_VALID, 8'h12);
    send_frame(8'h12, 1'b0, 1'b1);
    bit_out(1'b1);
    expect_pulse(K_FERR, 8'h12);
    send_frame(8'h55, 1'b0, 1'b0);
    bit_out(1'b0);
    bit_out(1'b0);
    bit_out(1'b1);
    bit_out(1'b1);

    // Reset mid-frame after four data bits of 0xC3
    bit_out(1'b0);
    bit_out(1'b1); bit_out(1'b1); bit_out(1'b0); bit_out(1'b0);
    #3 rst = 1'b1;
    #1;
    check("midrst_data", 32'(data), 32'h00);
    check("midrst_valid", 32'(valid), 32'h0);
    check("midrst_frame_err", 32'(frame_err), 32'h0);
    check("midrst_parity_err", 32'(parity_err), 32'h0);
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    bit_out(1'b1);
    expect_pulse(K_VALID, 8'h3C);
    send_frame(8'h3C, 1'b0, 1'b1);
    bit_out(1'b1);

`ifdef UART_RX_PARITY_EN
    // 0x31 has three ones: parity bit 1 is correct, 0 is a mismatch
    expect_pulse(K_VALID, 8'h31);
    send_frame(8'h31, 1'b1, 1'b1);
    bit_out(1'b1);
    expect_pulse(K_PERR, 8'h31);
    send_frame(8'h31, 1'b0, 1'b1);
    bit_out(1'b1);
`endif

    // Drain with a bounded wait
    for (int i = 0; i < 4 * BIT && q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_pending", 32'(q.size()), 32'd0);
    check("pulse_count", 32'(popped), 32'(pushed));
    check("final_data", 32'(data), 32'(last_data));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 100000000, meaning the clk frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 115200, meaning the serial bit rate in bit/s.
REQ-003 The block SHALL have port clk  input  1  system clock, with all logic on the rising edge.
REQ-004 The block SHALL have port rst  input  1  reset: asynchronous, active-high.
REQ-005 The block SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-006 The block SHALL have port data  output  8  last correctly received byte.
REQ-007 The block SHALL have port valid  output  1  one-clk pulse marking a new byte on data.
REQ-008 The block SHALL have port frame_err  output  1  one-clk pulse on a bad stop bit.
REQ-009 The block SHALL have port parity_err  output  1  one-clk pulse on a parity mismatch; it is tied 0 when parity is compiled out.

Function
REQ-010 The block SHALL define the bit period BIT_CYC = CLK_FREQ/BAUD with integer truncation, held in a 16-bit counter; BIT_CYC >= 16 is required.
REQ-011 The block SHALL pass rx through a 2-flop synchronizer before any use; all references below are to the synchronized signal rx_s.
REQ-012 The block SHALL implement the FSM states IDLE, START, DATA, PARITY (present only with the macro) and STOP.
REQ-013 In IDLE, a high-to-low transition of rx_s SHALL move the FSM to START and clear the bit counter.
REQ-014 In START, at count BIT_CYC/2-1 (the mid-bit), rx_s=0 SHALL move the FSM to DATA with the counter cleared; rx_s=1 is a false start and SHALL return the FSM to IDLE with no output pulse.
REQ-015 In DATA, each bit SHALL be sampled at count BIT_CYC-1, so sampling stays at the bit centre; bits are LSB first into a shift register; after bit 7 the FSM SHALL go to PARITY if present, else to STOP.
REQ-016 In PARITY, the block SHALL sample at bit centre and compare against even parity of the 8 data bits; a mismatch SHALL set an internal error flag; the FSM then SHALL go to STOP.
REQ-017 In STOP, the block SHALL sample at bit centre; with rx_s=1 and no parity error flag it SHALL copy the shift register to data and pulse valid on the next clk.
REQ-018 In STOP, rx_s=0 SHALL pulse frame_err with data unchanged and valid=0.
REQ-019 In STOP, a parity error with a good stop bit SHALL pulse parity_err with data unchanged and valid=0.
REQ-020 Any error pulse SHALL clear the parity error flag.
REQ-021 The FSM SHALL return to IDLE at the stop-bit centre sample, not at the end of the stop bit, so a start bit immediately following a stop bit (zero idle gap) is received.
REQ-022 A line held low after a frame error SHALL NOT be detected as a new start bit until rx_s has been seen high in IDLE.
REQ-023 valid, frame_err and parity_err SHALL be mutually exclusive and each exactly 1 clk wide.
REQ-024 Latency from the stop-bit centre sample to the valid pulse SHALL be 1 clk.
REQ-025 data SHALL hold its value between valid pulses.

Reset
REQ-026 rst SHALL asynchronously force FSM=IDLE, counter=0, shift register=0, data=8'h00, valid=0, frame_err=0, parity_err=0, and both synchronizer flops=1.
REQ-027 An rst asserted mid-frame SHALL abort the frame with no pulse; reception SHALL resume with the first falling edge after rst deasserts.

Configuration
REQ-028 When macro UART_RX_PARITY_EN is defined, the frame SHALL be 1 start + 8 data + 1 even-parity + 1 stop bit, and parity_err SHALL be live.
REQ-029 When UART_RX_PARITY_EN is undefined, the frame SHALL be 1 start + 8 data + 1 stop bit, the PARITY state SHALL be absent, and parity_err SHALL be a constant 0.

Verification
REQ-030 Defaults (BIT_CYC=868): send 0x68 with a good stop bit -> single valid pulse with data=0x68; frame_err=0 and parity_err=0.
REQ-031 Send the 15 bytes 0x68 0x69 0x74 0x73 0x7A 0x32 0x30 0x32 0x34 0x33 0x31 0x31 0x32 0x35 0x39 back-to-back with zero idle -> 15 valid pulses with bytes in order and no errors.
REQ-032 Drive a 200-clk low glitch on an idle rx -> no pulses; FSM is back in IDLE; a following 0xA5 frame is received correctly.
REQ-033 Receive 0x12, then send 0x55 with stop=0 -> frame_err pulses once, valid=0, data stays 0x12.
REQ-034 Assert rst after 4 data bits of 0xC3 -> all outputs 0 with no pulse; after release, 0x3C is received with data=0x3C.
REQ-035 With UART_RX_PARITY_EN: 0x31 with parity=1 (correct) -> valid pulses with data=0x31; 0x31 with parity=0 -> parity_err pulses and valid=0.
